// File: rtl/div_unit.sv
// RV32M divider: divide-by-zero and signed-overflow fast paths, otherwise a
// restoring shift-subtract loop producing one quotient bit per cycle.
module div_unit #(
    parameter int unsigned size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [size-1:0] dividend_i,
    input  logic [size-1:0] divisor_i,
    input  logic            divisor_zero_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [size-1:0] result_o
);
    localparam int unsigned CW = $clog2(size) + 1;
    localparam logic [size-1:0] MIN_NEG = {1'b1, {(size-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t          r_state, w_next;
    logic [size-1:0] r_rem, r_quot, r_dvsr, r_result;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_q, r_neg_r, r_is_rem;

    logic            w_signed, w_is_rem, w_a_neg, w_b_neg, w_ovf, w_fast, w_accept;
    logic [size-1:0] w_a_mag, w_b_mag, w_fast_res;
    logic [size:0]   w_rem_sh, w_diff;
    logic            w_ge, w_last;
    logic [size-1:0] w_rem_nx, w_quot_nx, w_calc_res;

    always_comb begin
        w_signed = ~op_i[0];
        w_is_rem = op_i[1];
        w_a_neg  = w_signed & dividend_i[size-1];
        w_b_neg  = w_signed & divisor_i[size-1];
        w_a_mag  = w_a_neg ? -dividend_i : dividend_i;
        w_b_mag  = w_b_neg ? -divisor_i : divisor_i;
        w_ovf    = w_signed && (dividend_i == MIN_NEG) && (&divisor_i);
        w_fast   = divisor_zero_i | w_ovf;
        w_accept = start_i & ~flush_i & (r_state != CALC);
        if (divisor_zero_i) w_fast_res = w_is_rem ? dividend_i : '1;
        else                w_fast_res = w_is_rem ? '0 : dividend_i;
    end

    // Shifted remainder is size+1 bits wide so divisors >= 2^(size-1) still compare correctly
    always_comb begin
        w_rem_sh   = {r_rem, r_quot[size-1]};
        w_diff     = w_rem_sh - {1'b0, r_dvsr};
        w_ge       = ~w_diff[size];
        w_rem_nx   = w_ge ? w_diff[size-1:0] : w_rem_sh[size-1:0];
        w_quot_nx  = {r_quot[size-2:0], w_ge};
        w_last     = (r_cnt == CW'(1));
        w_calc_res = r_is_rem ? (r_neg_r ? -w_rem_nx : w_rem_nx)
                              : (r_neg_q ? -w_quot_nx : w_quot_nx);
    end

    always_comb begin
        w_next = r_state;
        if (flush_i) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: w_next = w_accept ? (w_fast ? DONE : CALC) : IDLE;
                CALC:       if (w_last) w_next = DONE;
                default:    w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rem    <= '0;
            r_quot   <= '0;
            r_dvsr   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_is_rem <= w_is_rem;
                if (w_fast) begin
                    r_result <= w_fast_res;
                end else begin
                    r_rem   <= '0;
                    r_quot  <= w_a_mag;
                    r_dvsr  <= w_b_mag;
                    r_cnt   <= CW'(size);
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                end
            end else if (r_state == CALC && !flush_i) begin
                r_rem  <= w_rem_nx;
                r_quot <= w_quot_nx;
                r_cnt  <= r_cnt - CW'(1);
                if (w_last) r_result <= w_calc_res;
            end
        end
    end

    assign busy_o   = (r_state == CALC);
    assign valid_o  = (r_state == DONE);
    assign result_o = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected result and arrival
// cycle; the monitor pops on valid_o and also tracks busy_o and result_o hold.
module tb_div_unit;
    localparam int unsigned SZ = 32;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    logic          clk, reset, start_i, divisor_zero_i, flush_i;
    logic [1:0]    op_i;
    logic [SZ-1:0] dividend_i, divisor_i;
    logic          busy_o, valid_o;
    logic [SZ-1:0] result_o;

    div_unit #(.size(SZ)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i),
        .divisor_zero_i(divisor_zero_i), .flush_i(flush_i),
        .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
    );

    typedef struct {
        logic [SZ-1:0] res;
        int unsigned   cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc;
    int unsigned n_chk, n_fail;
    logic        exp_busy;
    logic        done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    initial begin : monitor
        exp_t          e;
        logic [SZ-1:0] last_res;
        n_chk = 0;
        n_fail = 0;
        last_res = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("reset_busy", {31'd0, busy_o}, 32'd0);
                check("reset_valid", {31'd0, valid_o}, 32'd0);
                check("reset_result", result_o, 32'd0);
                last_res = '0;
            end else begin
                if (valid_o) begin
                    if (q.size() == 0) begin
                        check("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("result", result_o, e.res);
                        check("valid_cycle", cyc, e.cyc);
                        last_res = e.res;
                    end
                end
                check("result_hold", result_o, last_res);
                check("busy", {31'd0, busy_o}, {31'd0, exp_busy});
            end
            if (done) begin
                check("pending_results", q.size(), 32'd0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic z);
        op_i = op;
        dividend_i = a;
        divisor_i = b;
        divisor_zero_i = z;
        start_i = 1'b1;
    endtask

    // Issue one op; fast selects 1-cycle latency, spur pulses a stray start in that CALC cycle
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic z, input logic [31:0] expv, input bit fast, input int spur);
        exp_t e;
        @(posedge clk); #1;
        drive(op, a, b, z);
        e.res = expv;
        e.cyc = cyc + (fast ? 1 : SZ + 1);
        q.push_back(e);
        @(posedge clk); #1;
        start_i = 1'b0;
        exp_busy = !fast;
        if (!fast) begin
            for (int k = 2; k <= int'(SZ); k++) begin
                @(posedge clk); #1;
                start_i = (k == spur);
                if (k == spur) begin
                    op_i = OP_DIVU;
                    dividend_i = 32'd50;
                    divisor_i = 32'd5;
                    divisor_zero_i = 1'b0;
                end
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            exp_busy = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin : stim
        done = 1'b0;
        exp_busy = 1'b0;
        reset = 1'b1;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i = '0;
        dividend_i = '0;
        divisor_i = '0;
        divisor_zero_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd14, 1'b0, 0);
        run_op(OP_REMU, 32'd100, 32'd7, 1'b0, 32'd2, 1'b0, 0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 1'b0, 0);
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b0, 32'hFFFF_FFF2, 1'b0, 0);
        run_op(OP_REM, 32'd100, 32'hFFFF_FFF9, 1'b0, 32'd2, 1'b0, 0);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd1, 1'b0, 0);
        run_op(OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'h7FFF_FFFF, 1'b0, 0);
        run_op(OP_DIVU, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(OP_REMU, 32'd5, 32'd0, 1'b1, 32'd5, 1'b1, 0);
        run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(OP_REM, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFB, 1'b1, 0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 0);
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1, 0);

        // Flush at cycle 10 of DIVU 1000/3: no result, then DIVU 9/3 from cycle 12
        @(posedge clk); #1;
        drive(OP_DIVU, 32'd1000, 32'd3, 1'b0);
        @(posedge clk); #1;
        start_i = 1'b0;
        exp_busy = 1'b1;
        for (int k = 2; k <= 10; k++) begin
            @(posedge clk); #1;
            flush_i = (k == 10);
        end
        @(posedge clk); #1;
        flush_i = 1'b0;
        exp_busy = 1'b0;
        run_op(OP_DIVU, 32'd9, 32'd3, 1'b0, 32'd3, 1'b0, 0);

        // Stray start during CALC must be ignored
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd14, 1'b0, 5);

        // Reset at cycle 15 of an operation: outputs clear, no result afterwards
        @(posedge clk); #1;
        drive(OP_DIVU, 32'd100, 32'd7, 1'b0);
        @(posedge clk); #1;
        start_i = 1'b0;
        exp_busy = 1'b1;
        for (int k = 2; k <= 14; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        exp_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) @(posedge clk);
        #1 done = 1'b1;
    end

endmodule
